// File: rtl/gray_pkg.sv
// ============================================================================
// Module   : gray_pkg
// Purpose  : Shared Gray/binary conversion helpers and counter width limits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

  localparam int c_WIDTH_MIN = 2;
  localparam int c_WIDTH_MAX = 16;

  // Helpers operate on the widest legal word; callers zero-extend and truncate.
  typedef logic [c_WIDTH_MAX-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[c_WIDTH_MAX-1] = g[c_WIDTH_MAX-1];
    for (int i = c_WIDTH_MAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_to_bin.sv
// ============================================================================
// Module   : gray_to_bin
// Purpose  : Combinational Gray-to-binary XOR prefix chain, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic [WIDTH-1:0] chain;

  always_comb begin
    chain[WIDTH-1] = gray_i[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      chain[i] = chain[i+1] ^ gray_i[i];
    end
  end

  assign bin_o = chain;

endmodule

`default_nettype wire

// File: rtl/gray_updown_counter.sv
// ============================================================================
// Module   : gray_updown_counter
// Purpose  : Up/down Gray counter with enable, clear, load, wrap/saturate ends.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_i,
  input  logic             up_i,
  input  logic             sclr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             tc_o,
  output logic             ceo_o
);

  generate
    if (WIDTH < c_WIDTH_MIN || WIDTH > c_WIDTH_MAX) begin : g_width_check
      $error("gray_updown_counter: WIDTH out of range");
    end
  endgenerate

  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_MAX = '1;

  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] din_bin;
  logic             at_end;

  gray_to_bin #(.WIDTH(WIDTH)) u_din_to_bin (
    .gray_i (din_i),
    .bin_o  (din_bin)
  );

  assign at_end = up_i ? (bin_q == c_MAX) : (bin_q == '0);
  assign tc_o   = at_end;
  assign ceo_o  = ce_i & at_end & ~sclr_i & ~load_i;

  // At a range end a saturating counter simply skips the step.
  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    if (sclr_i) begin
      bin_d  = '0;
      gray_d = '0;
    end else if (load_i) begin
      bin_d  = din_bin;
      gray_d = din_i;
    end else if (ce_i && (WRAP || !at_end)) begin
      bin_d  = up_i ? (bin_q + c_ONE) : (bin_q - c_ONE);
      gray_d = WIDTH'(bin2gray(gray_word_t'(bin_d)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign gray_o = gray_q;
  assign bin_o  = bin_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_updown_counter.sv
// ============================================================================
// Module   : tb_gray_updown_counter
// Purpose  : Self-checking bench: directed WIDTH=4 scenarios, cascade, and
//            randomized WIDTH=8 run against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_updown_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=4 stimulus shared by the wrap (A), saturate (B) and cascade-upper (C) stages
  logic       a_ce, a_up, a_sclr, a_load;
  logic [3:0] a_din;
  logic [3:0] a_gray, a_bin, b_gray, b_bin, c_gray, c_bin;
  logic       a_tc, a_ceo, b_tc, b_ceo, c_tc, c_ceo;

  // WIDTH=8 stimulus shared by the wrap (D) and saturate (E) stages
  logic       d_ce, d_up, d_sclr, d_load;
  logic [7:0] d_din;
  logic [7:0] d_gray, d_bin, e_gray, e_bin;
  logic       d_tc, d_ceo, e_tc, e_ceo;

  gray_updown_counter #(.WIDTH(4), .WRAP(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .ce_i(a_ce), .up_i(a_up), .sclr_i(a_sclr),
    .load_i(a_load), .din_i(a_din), .gray_o(a_gray), .bin_o(a_bin),
    .tc_o(a_tc), .ceo_o(a_ceo));

  gray_updown_counter #(.WIDTH(4), .WRAP(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .ce_i(a_ce), .up_i(a_up), .sclr_i(a_sclr),
    .load_i(a_load), .din_i(a_din), .gray_o(b_gray), .bin_o(b_bin),
    .tc_o(b_tc), .ceo_o(b_ceo));

  gray_updown_counter #(.WIDTH(4), .WRAP(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .ce_i(a_ceo), .up_i(a_up), .sclr_i(a_sclr),
    .load_i(a_load), .din_i(a_din), .gray_o(c_gray), .bin_o(c_bin),
    .tc_o(c_tc), .ceo_o(c_ceo));

  gray_updown_counter #(.WIDTH(8), .WRAP(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .ce_i(d_ce), .up_i(d_up), .sclr_i(d_sclr),
    .load_i(d_load), .din_i(d_din), .gray_o(d_gray), .bin_o(d_bin),
    .tc_o(d_tc), .ceo_o(d_ceo));

  gray_updown_counter #(.WIDTH(8), .WRAP(1'b0)) u_e (
    .clk(clk), .rst_n(rst_n), .ce_i(d_ce), .up_i(d_up), .sclr_i(d_sclr),
    .load_i(d_load), .din_i(d_din), .gray_o(e_gray), .bin_o(e_bin),
    .tc_o(e_tc), .ceo_o(e_ceo));

  int n_tests = 0;
  int n_fail  = 0;
  int ma, mb, mc, md, me;   // model counts, plain binary integers

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: range arithmetic straight from the behavioural rules.
  function automatic int step(int m, int w, bit wrap, bit sclr, bit load, bit ce, bit up, int dinb);
    int mx = (1 << w) - 1;
    if (sclr) return 0;
    if (load) return dinb;
    if (!ce)  return m;
    if (up)   return (m == mx) ? (wrap ? 0 : mx) : m + 1;
    return (m == 0) ? (wrap ? mx : 0) : m - 1;
  endfunction

  function automatic bit tcf(int m, int w, bit up);
    return up ? (m == (1 << w) - 1) : (m == 0);
  endfunction

  function automatic int b2g(int b);
    return b ^ (b >> 1);
  endfunction

  // Gray -> binary as the XOR of all right shifts of the code word.
  function automatic int g2b(int g);
    int b = 0;
    for (int k = 0; k < 16; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic int popcount(int v);
    int c = 0;
    for (int k = 0; k < 32; k++) c += (v >> k) & 1;
    return c;
  endfunction

  task automatic chk_dut(input string n, input int m, input int w, input bit up, input bit ce,
                         input bit sclr, input bit load, input logic [31:0] g,
                         input logic [31:0] b, input logic tc, input logic ceo);
    bit etc = tcf(m, w, up);
    chk({n, ".gray"}, g, b2g(m));
    chk({n, ".bin"},  b, m);
    chk({n, ".tc"},   {31'd0, tc},  {31'd0, etc});
    chk({n, ".ceo"},  {31'd0, ceo}, {31'd0, ce & etc & !sclr & !load});
  endtask

  // One clock: check every stage mid-cycle, then advance the models over the edge.
  task automatic cycle();
    bit c_ce;
    @(negedge clk);
    c_ce = a_ce & tcf(ma, 4, a_up) & !a_sclr & !a_load;
    chk_dut("A", ma, 4, a_up, a_ce, a_sclr, a_load, 32'(a_gray), 32'(a_bin), a_tc, a_ceo);
    chk_dut("B", mb, 4, a_up, a_ce, a_sclr, a_load, 32'(b_gray), 32'(b_bin), b_tc, b_ceo);
    chk_dut("C", mc, 4, a_up, c_ce, a_sclr, a_load, 32'(c_gray), 32'(c_bin), c_tc, c_ceo);
    chk_dut("D", md, 8, d_up, d_ce, d_sclr, d_load, 32'(d_gray), 32'(d_bin), d_tc, d_ceo);
    chk_dut("E", me, 8, d_up, d_ce, d_sclr, d_load, 32'(e_gray), 32'(e_bin), e_tc, e_ceo);
    @(posedge clk);
    ma = step(ma, 4, 1'b1, a_sclr, a_load, a_ce, a_up, g2b(int'(a_din)));
    mb = step(mb, 4, 1'b0, a_sclr, a_load, a_ce, a_up, g2b(int'(a_din)));
    mc = step(mc, 4, 1'b1, a_sclr, a_load, c_ce, a_up, g2b(int'(a_din)));
    md = step(md, 8, 1'b1, d_sclr, d_load, d_ce, d_up, g2b(int'(d_din)));
    me = step(me, 8, 1'b0, d_sclr, d_load, d_ce, d_up, g2b(int'(d_din)));
    #1;
  endtask

  initial begin
    logic [3:0] prev;
    rst_n = 1'b0;
    {a_ce, a_up, a_sclr, a_load, a_din} = '0;
    {d_ce, d_up, d_sclr, d_load, d_din} = '0;
    ma = 0; mb = 0; mc = 0; md = 0; me = 0;

    // Reset state, down direction: tc asserted while held in reset
    #3;
    chk("rst.gray", 32'(a_gray), 32'd0);
    chk("rst.bin",  32'(a_bin),  32'd0);
    chk("rst.tc",   32'(a_tc),   32'd1);
    chk("rst.ceo",  32'(a_ceo),  32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full up sweep with single-bit Gray steps
    a_ce = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prev = a_gray;
      cycle();
      chk("t1.hamming", popcount(int'(prev ^ a_gray)), 1);
    end
    chk("t1.wrap0", 32'(a_gray), 32'd0);

    // Down from zero: wrap to max on A, hold at zero on B
    a_sclr = 1'b1; a_ce = 1'b0;
    cycle();
    a_sclr = 1'b0; a_ce = 1'b1; a_up = 1'b0;
    cycle();
    chk("t2.wrapgray", 32'(a_gray), 32'b1000);
    chk("t2.wrapbin",  32'(a_bin),  32'd15);
    for (int i = 0; i < 3; i++) begin
      chk("t2.satgray", 32'(b_gray), 32'd0);
      chk("t2.sattc",   32'(b_tc),   32'd1);
      chk("t2.satceo",  32'(b_ceo),  32'd1);
      cycle();
    end

    // Load without ce, then sclr overriding load
    a_ce = 1'b0; a_load = 1'b1; a_din = 4'b0110;
    cycle();
    chk("t3.loadgray", 32'(a_gray), 32'b0110);
    chk("t3.loadbin",  32'(a_bin),  32'b0100);
    a_sclr = 1'b1;
    cycle();
    chk("t3.sclrwins", 32'(a_gray), 32'd0);

    // Count to 7, then asynchronous reset pulse between edges
    a_sclr = 1'b0; a_load = 1'b0; a_ce = 1'b1; a_up = 1'b1;
    repeat (7) cycle();
    chk("t4.bin7", 32'(a_bin), 32'd7);
    #1 rst_n = 1'b0;
    #1;
    chk("t4.asyncgray", 32'(a_gray), 32'd0);
    chk("t4.asyncbin",  32'(a_bin),  32'd0);
    ma = 0; mb = 0; mc = 0; md = 0; me = 0;
    rst_n = 1'b1;
    cycle();
    chk("t4.resume", 32'(a_gray), 32'b0001);

    // Cascade A.ceo -> C.ce for 40 enables
    a_sclr = 1'b1;
    cycle();
    a_sclr = 1'b0;
    repeat (40) cycle();
    chk("t5.upper", 32'(c_bin), 32'd2);
    chk("t5.lower", 32'(a_bin), 32'd8);

    // Randomized run on all stages
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(63) == 0) d_up = ~d_up;
      d_ce   = ($urandom_range(3) != 0);
      d_sclr = ($urandom_range(63) == 0);
      d_load = ($urandom_range(31) == 0);
      d_din  = 8'($urandom);
      if ($urandom_range(15) == 0) a_up = ~a_up;
      a_ce   = ($urandom_range(3) != 0);
      a_sclr = ($urandom_range(63) == 0);
      a_load = ($urandom_range(31) == 0);
      a_din  = 4'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
